seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Multiplexed N-digit hex 7-segment display driver. Latches a packed hex value and
//  scans one digit at a time via anode enables, decoding each nibble to segments a..g.
//  Adds tear-free frame-synchronous update, per-digit blanking, decimal points,
//  leading-zero suppression and anti-ghosting dead time. Sits between datapath and board pins.
// PARAMETERS
//  NUM_DIGITS  4      digits scanned, legal 1..8; IDXW = max(1,$clog2(NUM_DIGITS))
//  CLK_DIV     50000  clk cycles per digit slot, legal >= 2
//  BLANK_CYC   500    dead-time cycles at start of each slot (anodes off), legal 0..CLK_DIV-1
//  SEG_ACT_LOW 1      1: segment/dp outputs active-low; 0: active-high
//  AN_ACT_LOW  1      1: anode outputs active-low; 0: active-high
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             asynchronous active-low reset
//  value_in    in   4*NUM_DIGITS  hex nibbles, digit i = value_in[4i+3:4i], digit 0 rightmost
//  dp_in       in   NUM_DIGITS    decimal point request per digit
//  blank_in    in   NUM_DIGITS    force digit dark (segments and dp off)
//  load        in   1             strobe: capture value_in/dp_in/blank_in
//  lz_suppress in   1             1: blank leading zero digits (sampled live)
//  seg_out     out  [0:6]         segments a..g, seg_out[0]=a .. seg_out[6]=g
//  dp_out      out  1             decimal point segment
//  an_out      out  NUM_DIGITS    digit enables, bit i drives digit i
//  frame_done  out  1             1-cycle pulse at each frame wrap
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, idx=0, pending/active regs=0, pend=0, frame_done=0,
//   all segments/dp/anodes driven to their inactive level (SEG_ACT_LOW=1 -> seg_out=7'b1111111).
//  Prescaler: cnt counts 0..CLK_DIV-1; tick when cnt==CLK_DIV-1 -> cnt=0, idx advances;
//   idx wraps NUM_DIGITS-1 -> 0 (frame wrap). NUM_DIGITS=1: every tick is a frame wrap.
//  Load: load=1 captures inputs into pending regs, sets pend. At frame wrap with pend=1:
//   active <= pending, pend <= 0. Load on the wrap cycle itself writes inputs straight
//   into active, pend <= 0. Repeated loads within a frame: last one wins.
//  frame_done=1 for exactly the cycle after each frame wrap tick, regardless of pend.
//  Decode (active-low form, a..g), per active nibble:
//   0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111
//   8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000
//   SEG_ACT_LOW=0 inverts all of seg_out/dp_out; AN_ACT_LOW=0 inverts an_out.
//  Digit dark if blank_in bit (active copy) set, or lz_suppress=1 and its nibble and all
//   higher nibbles are 0; digit 0 never LZ-suppressed. LZ-suppressed digit keeps its dp.
//  Dead time: while cnt < BLANK_CYC no anode asserted, segments off.
//  Otherwise exactly one anode (bit idx) asserted; a dark digit asserts its anode, segs off.
//  Outputs registered: seg_out/dp_out/an_out reflect cnt/idx/active one cycle later.
//  Never more than one anode active in any cycle, including across reset release.
// TESTING (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, active-low both)
//  Reset mid-scan: assert rst_n=0 at idx=2 -> same cycle an_out=4'b1111, seg_out=7'b1111111,
//   frame_done=0; after release digit 0 selected first.
//  load value_in=16'h12AF, dp_in=0 -> after next wrap, scan shows an_out 1110/1101/1011/0111
//   with seg_out 0111000/0001000/0010010/1001111, each for 3 cycles after 1 dead cycle.
//  Tear-free: load 16'h0000 mid-frame -> remaining digits of that frame still show old
//   value; change visible only after frame_done pulse.
//  lz_suppress=1, value 16'h0050, dp_in=4'b1000 -> digits 3,2 segs off (digit 3 dp_out=0),
//   digit 1 shows 5 (0100100), digit 0 shows 0 (0000001); value 0 -> only digit 0 lit.
//  load coincident with wrap tick -> new value shown in digit 0 of the frame starting then.
//  Sweep all 16 nibbles and blank_in=4'b0100 -> table match, digit 2 dark with anode active.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex 7-segment scanner with frame-synchronous update,
// per-digit blanking, decimal points, leading-zero suppression and anti-ghosting dead time.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  output logic [0:6]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  localparam int IDXW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = $clog2(CLK_DIV);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(CLK_DIV - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [CNTW-1:0]         r_cnt;
  logic [IDXW-1:0]         r_idx;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_pend_blank, r_act_dp, r_act_blank;
  logic                    w_tick, w_wrap, w_dead, w_lz, w_dark, w_dp_low;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_low;
  logic [NUM_DIGITS-1:0]   w_hot, w_hi_zero;
  // w_hi_zero[i]: digit i and every digit above it hold zero
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hz
    assign w_hi_zero[g] = ~|r_act_val[4*NUM_DIGITS-1:4*g];
  end
  always_comb begin
    w_tick    = r_cnt == LAST_CNT;
    w_wrap    = w_tick && r_idx == LAST_IDX;
    w_dead    = int'(r_cnt) < BLANK_CYC;
    w_nib     = r_act_val[4*r_idx +: 4];
    w_lz      = lz_suppress && r_idx != '0 && w_hi_zero[r_idx];
    w_dark    = r_act_blank[r_idx] || w_lz;
    w_seg_low = (w_dead || w_dark) ? 7'h7F : SEG_LUT[w_nib];
    w_dp_low  = w_dead || !r_act_dp[r_idx] || r_act_blank[r_idx];
    w_hot     = w_dead ? '0 : NUM_DIGITS'(1) << r_idx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNTW'(1);
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IDXW'(1);
    end
  end
  // Display data only changes at a frame wrap so a frame never mixes two values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= 1'b0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else begin
      if (load) begin
        r_pend_val   <= value_in;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
      end
      if (w_wrap) begin
        r_pend <= 1'b0;
        if (load) begin
          r_act_val   <= value_in;
          r_act_dp    <= dp_in;
          r_act_blank <= blank_in;
        end else if (r_pend) begin
          r_act_val   <= r_pend_val;
          r_act_dp    <= r_pend_dp;
          r_act_blank <= r_pend_blank;
        end
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= {7{SEG_ACT_LOW}};
      dp_out     <= SEG_ACT_LOW;
      an_out     <= {NUM_DIGITS{AN_ACT_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg_out    <= SEG_ACT_LOW ? w_seg_low : ~w_seg_low;
      dp_out     <= SEG_ACT_LOW ? w_dp_low : !w_dp_low;
      an_out     <= AN_ACT_LOW ? ~w_hot : w_hot;
      frame_done <= w_wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; stimulus queues expected lit-digit outputs per frame,
// a negedge monitor pops and compares whenever an anode is driven.
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [0:6]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_q [$];
  logic [6:0]  lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1),
                     .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .lz_suppress(lz_suppress),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(~an_out) > 1) begin
        failures++;
        $display("FAIL onehot: an_out=%b has more than one active anode", an_out);
      end
      if (exp_q.size() > 0) begin
        if (an_out != 4'b1111) begin
          logic [11:0] e;
          e = exp_q.pop_front();
          checks++;
          if ({an_out, seg_out, dp_out} !== e) begin
            failures++;
            $display("FAIL scan: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                     an_out, seg_out, dp_out, e[11:8], e[7:1], e[0]);
          end
        end else begin
          checks++;
          if (seg_out !== 7'h7F || dp_out !== 1'b1) begin
            failures++;
            $display("FAIL dead: got seg=%b dp=%b expected seg=1111111 dp=1", seg_out, dp_out);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                            input logic lz);
    for (int d = 0; d < 4; d++) begin
      logic       dark;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpl;
      dark = bl[d] || (lz && d != 0 && (v >> (4 * d)) == 16'h0);
      an   = ~(4'b0001 << d);
      seg  = dark ? 7'h7F : lut[v[4*d +: 4]];
      dpl  = !(dp[d] && !bl[d]);
      repeat (3) exp_q.push_back({an, seg, dpl});
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz);
    value_in = v; dp_in = dp; blank_in = bl; lz_suppress = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    if (!seen) begin
      failures++;
      $display("FAIL frame_timeout: frame_done not seen within 64 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d expected entries left", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_and_check(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                                input logic lz);
    drain();
    do_load(v, dp, bl, lz);
    wait_frame();
    @(posedge clk);
    push_frame(v, dp, bl, lz);
  endtask

  initial begin
    logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    bit hit;
    repeat (3) @(negedge clk);
    check("rst_an", {12'h0, an_out}, 16'h000F);
    check("rst_seg", {9'h0, seg_out}, 16'h007F);
    check("rst_dp", {15'h0, dp_out}, 16'h0001);
    check("rst_fd", {15'h0, frame_done}, 16'h0000);
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      hit = an_out == 4'b1011;
    end
    check("reach_idx2", {15'h0, hit}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("midrst_an", {12'h0, an_out}, 16'h000F);
    check("midrst_seg", {9'h0, seg_out}, 16'h007F);
    check("midrst_fd", {15'h0, frame_done}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge clk);
      hit = an_out != 4'b1111;
    end
    check("first_digit_after_rst", {12'h0, an_out}, 16'h000E);
    load_and_check(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b0);
    wait_frame();
    @(posedge clk);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    load_and_check(16'h0050, 4'b1000, 4'b0000, 1'b1);
    load_and_check(16'h0000, 4'b0000, 4'b0000, 1'b1);
    drain();
    wait_frame();
    repeat (15) @(negedge clk);
    value_in = 16'hC0DE; dp_in = 4'b0001; blank_in = 4'b0000; lz_suppress = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("wrap_coincident_fd", {15'h0, frame_done}, 16'h0001);
    @(posedge clk);
    push_frame(16'hC0DE, 4'b0001, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) load_and_check(sweep[i], 4'b0000, 4'b0000, 1'b0);
    load_and_check(16'h3210, 4'b0110, 4'b0100, 1'b0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
